// File: rtl/pn_seq_ctrl.sv
// Polish-notation sequencing controller: buffers a prefix/postfix token burst,
// walks it in notation order with an operand stack, and issues each operator to an external ALU.
module pn_seq_ctrl #(
  parameter int unsigned MAX_TOK = 15,
  parameter int unsigned DW      = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [2:0]    in,
  input  logic          operator,
  input  logic          mode,
  output logic          alu_req,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic          alu_ack,
  input  logic [DW-1:0] alu_res,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] out,
  output logic          err
);

  localparam int unsigned PW    = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;
  localparam int unsigned CW    = $clog2(MAX_TOK + 1);
  localparam int unsigned DEPTH = 1 << PW;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, sp_q, sp_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_nx;
  logic          mode_q, mode_d, ovf_q, ovf_d;
  logic          alu_req_q, alu_req_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic          busy_q, busy_d, out_valid_q, out_valid_d, err_q, err_d;
  logic [DW-1:0] out_q, out_d;

  logic [3:0]    tok_q [DEPTH];
  logic [DW-1:0] stk_q [DEPTH];
  logic          tok_we, stk_we;
  logic [PW-1:0] tok_wa, stk_wa;
  logic [3:0]    tok_wd;
  logic [DW-1:0] stk_wd;

  logic [3:0]    cur;
  logic [DW-1:0] top, nxt, fin_val;
  logic          last, fin, fin_ok;

  assign cur    = tok_q[ptr_q];
  assign top    = stk_q[PW'(sp_q - CW'(1))];
  assign nxt    = stk_q[PW'(sp_q - CW'(2))];
  assign last   = mode_q ? (CW'(ptr_q) == cnt_q - CW'(1)) : (ptr_q == '0);
  assign ptr_nx = mode_q ? ptr_q + PW'(1) : ptr_q - PW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sp_d        = sp_q;
    ptr_d       = ptr_q;
    mode_d      = mode_q;
    ovf_d       = ovf_q;
    alu_req_d   = alu_req_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    out_valid_d = 1'b0;
    out_d       = '0;
    err_d       = 1'b0;
    tok_we      = 1'b0;
    tok_wa      = cnt_q[PW-1:0];
    tok_wd      = {operator, in};
    stk_we      = 1'b0;
    stk_wa      = sp_q[PW-1:0];
    stk_wd      = DW'(cur[2:0]);
    fin         = 1'b0;
    fin_ok      = 1'b0;
    fin_val     = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tok_we  = 1'b1;
          tok_wa  = '0;
          cnt_d   = CW'(1);
          sp_d    = '0;
          ovf_d   = 1'b0;
          mode_d  = mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q < CW'(MAX_TOK)) begin
            tok_we = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (ovf_q) begin
          fin = 1'b1;
        end else begin
          state_d = S_SCAN;
          ptr_d   = mode_q ? '0 : PW'(cnt_q - CW'(1));
        end
      end
      S_SCAN: begin
        if (!cur[3]) begin
          stk_we = 1'b1;
          sp_d   = sp_q + CW'(1);
          if (last) begin
            fin     = 1'b1;
            fin_ok  = (sp_q == '0);
            fin_val = stk_wd;
          end else begin
            ptr_d = ptr_nx;
          end
        end else if (cur[2] || sp_q < CW'(2)) begin
          fin = 1'b1;
        end else begin
          // Stack pointer drops by two now; the ALU result is pushed back on ack.
          alu_req_d = 1'b1;
          alu_op_d  = cur[2:0];
          alu_a_d   = mode_q ? nxt : top;
          alu_b_d   = mode_q ? top : nxt;
          sp_d      = sp_q - CW'(2);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (alu_ack) begin
          alu_req_d = 1'b0;
          stk_we    = 1'b1;
          stk_wd    = alu_res;
          sp_d      = sp_q + CW'(1);
          if (last) begin
            fin     = 1'b1;
            fin_ok  = (sp_q == '0);
            fin_val = alu_res;
          end else begin
            ptr_d   = ptr_nx;
            state_d = S_SCAN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        sp_d    = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d     = S_DONE;
      out_valid_d = 1'b1;
      err_d       = !fin_ok;
      out_d       = fin_ok ? fin_val : '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sp_q        <= '0;
      ptr_q       <= '0;
      mode_q      <= 1'b0;
      ovf_q       <= 1'b0;
      alu_req_q   <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
      ptr_q       <= ptr_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      alu_req_q   <= alu_req_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tok_we) tok_q[tok_wa] <= tok_wd;
    if (stk_we) stk_q[stk_wa] <= stk_wd;
  end

  assign alu_req   = alu_req_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pn_seq_ctrl.sv
// Bench for pn_seq_ctrl: directed table, reset-in-WAIT sequence and random expressions
// checked against a stack-evaluation reference model with a delayed-ack ALU.
module tb_pn_seq_ctrl;

  typedef logic [130:0] req_t;
  typedef struct packed {
    logic [63:0] toks;
    int unsigned n;
  } expr_t;
  typedef struct {
    expr_t       e;
    bit          mode;
    int          delay;
    logic [63:0] xout;
    bit          xerr;
    int          xlat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, operator, mode;
  logic [2:0]  in_tok;
  logic        alu_req, alu_ack;
  logic [2:0]  alu_op;
  logic [63:0] alu_a, alu_b, alu_res;
  logic        busy, out_valid, err;
  logic [63:0] out_data;

  int checks = 0;
  int errors = 0;

  pn_seq_ctrl #(.MAX_TOK(15), .DW(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_tok), .operator(operator), .mode(mode),
    .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ack(alu_ack), .alu_res(alu_res),
    .busy(busy), .out_valid(out_valid), .out(out_data), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_fn(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (a > b) ? a - b : b - a;
      default: return '0;
    endcase
  endfunction

  // External ALU: acks on the ack_delay-th cycle of a held request.
  int ack_delay;
  bit ack_en, force_ack;
  int req_age = 0;
  always @(posedge clk) req_age <= (alu_req && !alu_ack) ? req_age + 1 : 0;
  assign alu_ack = force_ack || (ack_en && alu_req && (req_age == ack_delay - 1));
  assign alu_res = force_ack ? 64'hDEAD_BEEF_0000_0001 : alu_fn(alu_op, alu_a, alu_b);

  req_t obs_reqs[$];
  int   obs_held[$];
  req_t exp_reqs[$];
  int   unstable;
  bit   req_prev = 1'b0;
  int   held = 0;
  always @(negedge clk) begin
    if (alu_req) begin
      if (!req_prev) begin
        obs_reqs.push_back({alu_op, alu_a, alu_b});
        held = 1;
      end else begin
        held = held + 1;
        if ({alu_op, alu_a, alu_b} != obs_reqs[$]) unstable = unstable + 1;
      end
      if (alu_ack) obs_held.push_back(held);
    end
    req_prev = alu_req;
  end

  function automatic void chk(input string nm, input logic [130:0] act, input logic [130:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic expr_t parse(input string s);
    expr_t e;
    byte c;
    logic [3:0] t;
    e.toks = '0;
    e.n = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      case (c)
        "+":     t = 4'b1000;
        "-":     t = 4'b1001;
        "*":     t = 4'b1010;
        "|":     t = 4'b1011;
        "#":     t = 4'b1101;
        default: t = {1'b0, c[2:0]};
      endcase
      if (c != " ") begin
        e.toks[4*e.n +: 4] = t;
        e.n = e.n + 1;
      end
    end
    return e;
  endfunction

  // Reference: evaluate with a queue as the stack; latency from the per-token cycle costs.
  function automatic void ref_eval(input expr_t e, input bit md, input int dly,
                                   output logic [63:0] r, output bit er, output int lat);
    logic [63:0] st[$];
    logic [63:0] t, u, a, b;
    logic [3:0] tk;
    int idx;
    exp_reqs.delete();
    r = '0;
    er = 1'b1;
    lat = 1;
    if (e.n > 15) return;
    for (int k = 0; k < int'(e.n); k++) begin
      idx = md ? k : int'(e.n) - 1 - k;
      tk = e.toks[4*idx +: 4];
      lat++;
      if (!tk[3]) begin
        st.push_back(64'(tk[2:0]));
      end else begin
        if (tk[2] || st.size() < 2) return;
        t = st.pop_back();
        u = st.pop_back();
        a = md ? u : t;
        b = md ? t : u;
        exp_reqs.push_back({tk[2:0], a, b});
        st.push_back(alu_fn(tk[2:0], a, b));
        lat += dly;
      end
    end
    if (st.size() == 1) begin
      r = st[0];
      er = 1'b0;
    end
  endfunction

  function automatic expr_t gen_expr(input bit md);
    expr_t e;
    logic [3:0] seq [16];
    int k, ro, ops, depth, n;
    e.toks = '0;
    e.n = 0;
    if ($urandom_range(0, 19) == 0) begin
      for (int i = 0; i < 16; i++) e.toks[4*i +: 4] = 4'($urandom);
      e.n = 16;
      return e;
    end
    k = $urandom_range(1, 8);
    ro = k;
    ops = k - 1;
    depth = 0;
    n = 0;
    while (ro > 0 || ops > 0) begin
      if (ops > 0 && depth >= 2 && (ro == 0 || $urandom_range(0, 1) == 1)) begin
        seq[n] = {2'b10, 2'($urandom)};
        ops--;
        depth--;
      end else begin
        seq[n] = {1'b0, 3'($urandom)};
        ro--;
        depth++;
      end
      n++;
    end
    if ($urandom_range(0, 3) == 0) seq[$urandom_range(0, n - 1)] = 4'($urandom);
    for (int i = 0; i < n; i++) e.toks[4*(md ? i : n - 1 - i) +: 4] = seq[i];
    e.n = n;
    return e;
  endfunction

  function automatic vec_t mkv(input string s, input bit md, input int dly,
                               input logic [63:0] xo, input bit xe, input int xl);
    vec_t v;
    v.e = parse(s);
    v.mode = md;
    v.delay = dly;
    v.xout = xo;
    v.xerr = xe;
    v.xlat = xl;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    force_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_burst(input expr_t e, input bit md);
    logic [3:0] t;
    for (int i = 0; i < int'(e.n); i++) begin
      @(posedge clk); #1;
      t = e.toks[4*i +: 4];
      in_valid = 1'b1;
      operator = t[3];
      in_tok = t[2:0];
      mode = (i == 0) ? md : 1'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_tok = 3'($urandom);
  endtask

  task automatic run_expr(input string nm, input expr_t e, input bit md, input int dly,
                          input logic [63:0] xo, input bit xe, input int xl, input bit noise);
    logic [63:0] mo;
    bit me, got;
    int ml, cyc, bad_out, not_busy;
    ref_eval(e, md, dly, mo, me, ml);
    obs_reqs.delete();
    obs_held.delete();
    unstable = 0;
    ack_delay = dly;
    drive_burst(e, md);
    cyc = 0;
    got = 1'b0;
    bad_out = 0;
    not_busy = 0;
    while (!got && cyc <= 400) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
      end else begin
        if (out_data != '0 || err) bad_out++;
        if (!busy) not_busy++;
        @(posedge clk); #1;
        cyc++;
        if (noise) begin
          in_valid = 1'($urandom);
          operator = 1'($urandom);
          in_tok = 3'($urandom);
        end
      end
    end
    in_valid = 1'b0;
    chk({nm, " done"}, 131'(got), 131'd1);
    chk({nm, " latency"}, 131'(cyc), 131'(xl));
    chk({nm, " out"}, 131'(out_data), 131'(xo));
    chk({nm, " err"}, 131'(err), 131'(xe));
    chk({nm, " busy at result"}, 131'(busy), 131'd1);
    chk({nm, " out zero while idle"}, 131'(bad_out), 131'd0);
    chk({nm, " busy during eval"}, 131'(not_busy), 131'd0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " valid one cycle"}, 131'(out_valid), 131'd0);
    chk({nm, " busy cleared"}, 131'(busy), 131'd0);
    chk({nm, " out cleared"}, 131'(out_data), 131'd0);
    chk({nm, " req count"}, 131'(obs_reqs.size()), 131'(exp_reqs.size()));
    for (int i = 0; i < exp_reqs.size() && i < obs_reqs.size(); i++)
      chk($sformatf("%s req%0d op/a/b", nm, i), obs_reqs[i], exp_reqs[i]);
    for (int i = 0; i < obs_held.size(); i++)
      chk($sformatf("%s req%0d hold", nm, i), 131'(obs_held[i]), 131'(dly));
    chk({nm, " req stable"}, 131'(unstable), 131'd0);
    if (!got) do_reset();
  endtask

  vec_t vecs[$];

  initial begin
    expr_t e;
    bit md;
    int dly, cyc, seen, ml;
    logic [63:0] mo;
    bit me;

    rst = 1'b1;
    in_valid = 1'b0;
    in_tok = '0;
    operator = 1'b0;
    mode = 1'b0;
    ack_delay = 1;
    ack_en = 1'b1;
    force_ack = 1'b0;
    unstable = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset alu_req", 131'(alu_req), 131'd0);
    chk("reset alu_op", 131'(alu_op), 131'd0);
    chk("reset alu_a", 131'(alu_a), 131'd0);
    chk("reset alu_b", 131'(alu_b), 131'd0);
    chk("reset busy", 131'(busy), 131'd0);
    chk("reset out_valid", 131'(out_valid), 131'd0);
    chk("reset out", 131'(out_data), 131'd0);
    chk("reset err", 131'(err), 131'd0);

    vecs.push_back(mkv("3 4 +",            1, 1, 64'd7,                  0, 5));
    vecs.push_back(mkv("- 2 5",            0, 1, 64'hFFFF_FFFF_FFFF_FFFD, 0, 5));
    vecs.push_back(mkv("2 3 * 1 +",        1, 4, 64'd7,                  0, 14));
    vecs.push_back(mkv("3 +",              1, 1, 64'd0,                  1, 3));
    vecs.push_back(mkv("3 4",              1, 1, 64'd0,                  1, 3));
    vecs.push_back(mkv("1111111111111111", 1, 1, 64'd0,                  1, 1));
    vecs.push_back(mkv("1 1 +",            1, 1, 64'd2,                  0, 5));
    vecs.push_back(mkv("2 7 |",            1, 2, 64'd5,                  0, 6));
    vecs.push_back(mkv("1 2 #",            1, 1, 64'd0,                  1, 4));
    vecs.push_back(mkv("* + 1 2 3",        0, 1, 64'd9,                  0, 8));
    vecs.push_back(mkv("- 7",              0, 1, 64'd0,                  1, 3));
    vecs.push_back(mkv("5",                1, 1, 64'd5,                  0, 2));
    vecs.push_back(mkv("6 2 - 3 *",        1, 2, 64'd12,                 0, 10));
    vecs.push_back(mkv("| 1 6",            0, 1, 64'd5,                  0, 5));
    foreach (vecs[i])
      run_expr($sformatf("vec%0d", i), vecs[i].e, vecs[i].mode, vecs[i].delay,
               vecs[i].xout, vecs[i].xerr, vecs[i].xlat, 1'b0);

    // Reset while a request is outstanding, then a stray ack.
    ack_en = 1'b0;
    drive_burst(parse("6 3 +"), 1'b1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!alu_req && cyc < 50);
    chk("rstwait req seen", 131'(alu_req), 131'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstwait alu_req", 131'(alu_req), 131'd0);
    chk("rstwait busy", 131'(busy), 131'd0);
    chk("rstwait out_valid", 131'(out_valid), 131'd0);
    chk("rstwait alu_a", 131'(alu_a), 131'd0);
    chk("rstwait alu_b", 131'(alu_b), 131'd0);
    chk("rstwait err", 131'(err), 131'd0);
    @(posedge clk); #1 force_ack = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || busy || alu_req || err) seen++;
    end
    force_ack = 1'b0;
    ack_en = 1'b1;
    chk("rstwait late ack ignored", 131'(seen), 131'd0);
    run_expr("after reset", parse("6 2 -"), 1'b1, 1, 64'd4, 1'b0, 5, 1'b0);

    for (int r = 0; r < 40; r++) begin
      md = 1'($urandom);
      dly = $urandom_range(1, 3);
      e = gen_expr(md);
      ref_eval(e, md, dly, mo, me, ml);
      run_expr($sformatf("rnd%0d", r), e, md, dly, mo, me, ml, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
